// File: rtl/div_recon_pkg.sv
// rtl/div_recon_pkg.sv - shared widths and FSM encoding for the q*d+r reconstruction block
package div_recon_pkg;

  localparam int QW_DEF = 8;
  localparam int DW_DEF = 8;
  localparam int NW_DEF = 16;
  localparam int MSE_W  = 40;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    CMP  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/div_recon_err_acc.sv
// rtl/div_recon_err_acc.sv - absolute error, squared-error accumulator and sample counter
module div_recon_err_acc
  import div_recon_pkg::*;
#(
  parameter int NW = NW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [NW-1:0]    n_ref,
  input  logic [NW-1:0]    n_val,
  output logic [NW-1:0]    err_abs,
  output logic [MSE_W-1:0] mse_acc,
  output logic [CNT_W-1:0] sample_cnt
);

  logic [NW-1:0]    err_q, err_d;
  logic [MSE_W-1:0] mse_q, mse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NW-1:0]    diff;
  logic [2*NW-1:0]  sq;
  logic [MSE_W:0]   sum;

  // Error measurement; a clear on the same cycle as an update discards the update.
  always_comb begin
    diff  = (n_ref >= n_val) ? (n_ref - n_val) : (n_val - n_ref);
    sq    = diff * diff;
    sum   = {1'b0, mse_q} + (MSE_W+1)'(sq);
    err_d = err_q;
    mse_d = mse_q;
    cnt_d = cnt_q;
    if (en) begin
      err_d = diff;
      mse_d = sum[MSE_W] ? {MSE_W{1'b1}} : sum[MSE_W-1:0];
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
    end
    if (clr) begin
      mse_d = '0;
      cnt_d = '0;
    end
  end

  // Accumulator registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
      mse_q <= '0;
      cnt_q <= '0;
    end else begin
      err_q <= err_d;
      mse_q <= mse_d;
      cnt_q <= cnt_d;
    end
  end

  assign err_abs    = err_q;
  assign mse_acc    = mse_q;
  assign sample_cnt = cnt_q;

endmodule

// File: rtl/div_reconstruct_mul_8.sv
// rtl/div_reconstruct_mul_8.sv - shift-and-add dividend rebuild n=q*d+r; RECON_ERR_ACC_EN adds error stats
module div_reconstruct_mul_8
  import div_recon_pkg::*;
#(
  parameter int QW = QW_DEF,
  parameter int DW = DW_DEF,
  parameter int NW = NW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [QW-1:0]    q,
  input  logic [DW-1:0]    d,
  input  logic [DW-1:0]    r,
  input  logic [NW-1:0]    n_ref,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NW-1:0]    n_out,
  output logic [NW-1:0]    err_abs,
  output logic [MSE_W-1:0] mse_acc,
  output logic [CNT_W-1:0] sample_cnt,
  input  logic             acc_clr
);

  localparam int CW = (QW > 1) ? $clog2(QW) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(QW - 1);

  state_e        state_q, state_d;
  logic [QW-1:0] q_sh_q, q_sh_d;
  logic [DW-1:0] dv_q, dv_d;
  logic [NW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cmp_en;
`ifdef RECON_ERR_ACC_EN
  logic [NW-1:0] n_ref_q, n_ref_d;
`endif

  // Next-state, datapath update and handshake outputs.
  always_comb begin
    state_d   = state_q;
    q_sh_d    = q_sh_q;
    dv_d      = dv_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    cmp_en    = 1'b0;
`ifdef RECON_ERR_ACC_EN
    n_ref_d   = n_ref_q;
`endif
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          q_sh_d  = q;
          dv_d    = d;
          acc_d   = NW'(r);
          cnt_d   = '0;
`ifdef RECON_ERR_ACC_EN
          n_ref_d = n_ref;
`endif
          state_d = MUL;
        end
      end
      MUL: begin
        // Always runs all QW iterations, even for zero operands.
        if (q_sh_q[0]) acc_d = acc_q + (NW'(dv_q) << cnt_q);
        q_sh_d = q_sh_q >> 1;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
`ifdef RECON_ERR_ACC_EN
          state_d = CMP;
`else
          state_d = DONE;
`endif
        end
      end
      CMP: begin
        cmp_en  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_sh_q  <= '0;
      dv_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
`ifdef RECON_ERR_ACC_EN
      n_ref_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      q_sh_q  <= q_sh_d;
      dv_q    <= dv_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
`ifdef RECON_ERR_ACC_EN
      n_ref_q <= n_ref_d;
`endif
    end
  end

  assign n_out = acc_q;

`ifdef RECON_ERR_ACC_EN
  div_recon_err_acc #(.NW(NW)) u_err_acc (
    .clk        (clk),
    .rst        (rst),
    .en         (cmp_en),
    .clr        (acc_clr),
    .n_ref      (n_ref_q),
    .n_val      (acc_q),
    .err_abs    (err_abs),
    .mse_acc    (mse_acc),
    .sample_cnt (sample_cnt)
  );
`else
  logic unused_inputs;
  assign unused_inputs = ^{n_ref, acc_clr, cmp_en};
  assign err_abs    = '0;
  assign mse_acc    = '0;
  assign sample_cnt = '0;
`endif

endmodule

// File: tb/tb_div_reconstruct_mul_8.sv
// tb/tb_div_reconstruct_mul_8.sv - randomized self-checking bench against an arithmetic reference model
module tb_div_reconstruct_mul_8;

`ifdef RECON_ERR_ACC_EN
  localparam bit ERR_EN = 1'b1;
  localparam int LAT    = 9;
`else
  localparam bit ERR_EN = 1'b0;
  localparam int LAT    = 8;
`endif
  localparam longint MSE_MAX = (longint'(1) << 40) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  q = '0, d = '0, r = '0;
  logic [15:0] n_ref = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] n_out;
  logic [15:0] err_abs;
  logic [39:0] mse_acc;
  logic [15:0] sample_cnt;
  logic        acc_clr = 1'b0;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint mse_m    = 0;
  longint cnt_m    = 0;

  div_reconstruct_mul_8 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .q(q), .d(d), .r(r), .n_ref(n_ref), .out_valid(out_valid),
    .out_ready(out_ready), .n_out(n_out), .err_abs(err_abs),
    .mse_acc(mse_acc), .sample_cnt(sample_cnt), .acc_clr(acc_clr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_stats(input string tag, input longint e_err);
    check_eq({tag, " err_abs"}, 64'(err_abs), ERR_EN ? 64'(e_err) : 64'd0);
    check_eq({tag, " mse_acc"}, 64'(mse_acc), ERR_EN ? 64'(mse_m) : 64'd0);
    check_eq({tag, " sample_cnt"}, 64'(sample_cnt), ERR_EN ? 64'(cnt_m) : 64'd0);
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that leaves DONE.
  task automatic run_txn(input logic [7:0] qi, input logic [7:0] di, input logic [7:0] ri,
                         input logic [15:0] nref, input int hold, input string tag);
    int     edges;
    longint exp_n, e_err;
    exp_n = longint'(qi) * longint'(di) + longint'(ri);
    e_err = (longint'(nref) > exp_n) ? longint'(nref) - exp_n : exp_n - longint'(nref);
    q = qi; d = di; r = ri; n_ref = nref; in_valid = 1'b1;
    check_eq({tag, " in_ready idle"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    q = $urandom; d = $urandom; r = $urandom; n_ref = $urandom;
    edges = 0;
    while (!out_valid && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    check_eq({tag, " latency"}, 64'(edges), 64'(LAT));
    if (!out_valid) return;
    if (cnt_m < 65535) cnt_m++;
    mse_m = mse_m + e_err * e_err;
    if (mse_m > MSE_MAX) mse_m = MSE_MAX;
    check_eq({tag, " n_out"}, 64'(n_out), 64'(exp_n));
    check_stats(tag, e_err);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      @(posedge clk); #1;
      check_eq({tag, " hold n_out"}, 64'(n_out), 64'(exp_n));
      check_eq({tag, " hold in_ready"}, 64'(in_ready), 64'd0);
      check_eq({tag, " hold out_valid"}, 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq({tag, " release out_valid"}, 64'(out_valid), 64'd0);
    check_eq({tag, " release in_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_eq("reset in_ready", 64'(in_ready), 64'd1);
    check_eq("reset out_valid", 64'(out_valid), 64'd0);
    check_eq("reset n_out", 64'(n_out), 64'd0);
    check_stats("reset", 0);

    run_txn(8'h0C, 8'h05, 8'h03, 16'h0040, 0, "t0c");
    run_txn(8'h0C, 8'h05, 8'h03, 16'h0000, 0, "t0c_ref0");

    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    if (ERR_EN) begin mse_m = 0; cnt_m = 0; end
    check_stats("acc_clr", 63);

    run_txn(8'hFF, 8'hFF, 8'hFE, 16'hFEFF, 0, "max");
    run_txn(8'h80, 8'h00, 8'h11, 16'h1234, 0, "dzero");
    run_txn(8'h00, 8'h9A, 8'h55, 16'h0055, 0, "qzero");
    run_txn(8'h37, 8'hA1, 8'h22, 16'hFFFF, 5, "bp");

    // Abort in the 4th MUL cycle.
    q = 8'hFF; d = 8'hFF; r = 8'hFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mse_m = 0; cnt_m = 0;
    check_eq("abort in_ready", 64'(in_ready), 64'd1);
    check_eq("abort out_valid", 64'(out_valid), 64'd0);
    check_eq("abort n_out", 64'(n_out), 64'd0);
    check_stats("abort", 0);
    run_txn(8'h02, 8'h03, 8'h01, 16'h0009, 0, "post_abort");

    for (int k = 0; k < 20; k++) begin
      run_txn(8'($urandom), 8'($urandom), 8'($urandom), 16'($urandom),
              int'($urandom_range(0, 2)), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/div_reconstruct_mul_8.md
# div_reconstruct_mul_8

- Sequential inverse of the 16/8 array divider: accepts a quotient/divisor/remainder triple and rebuilds the dividend as n = q·d + r.
- Uses an 8-iteration shift-and-add datapath behind a valid/ready handshake.
- Sits downstream of the approximate divider variants in characterization and power/MSE evaluation flows.
- With the error option enabled, it also measures the reconstruction error against a supplied reference dividend and accumulates squared error.

## Interface
Parameters:
- QW, 8, quotient width (iteration count)
- DW, 8, divisor and remainder width
- NW, 16, dividend/result width (QW+DW)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  triple presented
- in_ready  out  1  block can accept
- q  in  QW  quotient
- d  in  DW  divisor
- r  in  DW  remainder
- n_ref  in  NW  reference dividend; ignored unless RECON_ERR_ACC_EN
- out_valid  out  1  n_out valid
- out_ready  in  1  consumer accepts
- n_out  out  NW  reconstructed dividend
- err_abs  out  NW  |n_ref − n_out|; 0 without macro
- mse_acc  out  40  saturating sum of err_abs²; 0 without macro
- sample_cnt  out  16  saturating count of compared samples; 0 without macro
- acc_clr  in  1  synchronous clear of mse_acc and sample_cnt

## Operation
- FSM states: IDLE, MUL, CMP (macro only), DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch q, d, r and n_ref.
  - Set acc = zero-extended r and cnt = 0, then go to MUL.
- MUL, one iteration per cycle:
  - If q_reg[0]=1, acc += d_reg << cnt.
  - Shift q_reg right by 1 and increment cnt.
  - When cnt=QW−1: go to CMP if the macro is defined, else DONE.
- Arithmetic:
  - The maximum result is 255·255+255 = 65280, so there is no overflow and no carry-out is needed.
  - acc is NW bits, unsigned.
- CMP:
  - err_abs = |n_ref_reg − acc|.
  - mse_acc += err_abs², saturating at 2^40−1.
  - sample_cnt += 1, saturating at 0xFFFF.
  - Go to DONE.
- DONE:
  - out_valid=1; n_out=acc is held stable.
  - On out_ready, go to IDLE.
- in_ready=0 in every state except IDLE; inputs are not sampled outside IDLE.
- acc_clr:
  - Clears mse_acc and sample_cnt.
  - If it coincides with a CMP update, clear wins and the CMP contribution is dropped.
  - n_out and err_abs are unaffected.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, n_out=0, err_abs=0, mse_acc=0, sample_cnt=0.
- Latency, measured from the accepting edge:
  - out_valid rises after 8 edges without the macro, after 9 edges with it.
- Throughput: one result per 10 cycles (11 with macro) when out_ready is held high.
- Backpressure:
  - n_out and err_abs are held while out_valid=1 and out_ready=0.
  - No new accept occurs during backpressure.
- Reset asserted in any state aborts the operation and restores the reset values on the next edge.
  - A partial result is never emitted.
- d=0 or q=0: the result equals r. The iteration count stays fixed (no early exit).

## Configuration
- RECON_ERR_ACC_EN defined:
  - CMP state present; n_ref is used.
  - err_abs, mse_acc and sample_cnt are live.
  - Latency is 9.
- RECON_ERR_ACC_EN undefined:
  - No CMP state; n_ref is unused.
  - err_abs, mse_acc and sample_cnt are tied to 0; acc_clr has no effect.
  - Latency is 8.

## Structure
- Package div_recon_pkg holds:
  - QW/DW/NW defaults
  - MSE_W=40, CNT_W=16
  - the state enum {IDLE, MUL, CMP, DONE}
- Sub-module div_recon_err_acc provides the absolute difference, 16×16 square, saturating 40-bit accumulator and saturating sample counter.
  - It is instantiated only under RECON_ERR_ACC_EN.

## Test plan
- q=0x0C, d=0x05, r=0x03 → n_out=0x003F, out_valid 8 edges after accept (9 with macro).
- q=0xFF, d=0xFF, r=0xFE → n_out=0xFEFF; q=0x80, d=0x00, r=0x11 → n_out=0x0011.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → n_out stable, in_ready=0, then IDLE one edge after out_ready=1.
- Reset at the 4th MUL cycle → next cycle in_ready=1, out_valid=0, n_out=0; a subsequent q=2, d=3, r=1 → 0x0007.
- Macro, first pair: q=0x0C, d=0x05, r=0x03, n_ref=0x0040 → err_abs=1, mse_acc=1, sample_cnt=1.
- Macro, continued:
  - Next, n_ref=0x0000 with the same triple → err_abs=0x3F, mse_acc=3970.
  - Then acc_clr → mse_acc=0, sample_cnt=0.
